// File: rtl/feature_map_collector_pkg.sv
// Shared definitions for the feature-map collector, pool and serializer stages.
package feature_map_collector_pkg;

    // Collector state: filling the frame buffer, or holding a complete frame.
    typedef enum logic {
        FILL = 1'b0,
        FULL = 1'b1
    } state_e;

    // Default frame geometry shared across the pooling pipeline.
    localparam int unsigned FMC_DATA_BITS = 32;
    localparam int unsigned FMC_W         = 46;
    localparam int unsigned FMC_H         = 46;
    localparam int unsigned N_PIX         = FMC_H * FMC_W;

endpackage

// File: rtl/pixel_relu.sv
// Combinational ReLU on one pixel word: a set sign bit (int or IEEE float) clamps to zero.
// Instantiated by feature_map_collector only when RELU_EN is defined.
module pixel_relu #(
    parameter int unsigned DATA_BITS = 32
) (
    input  logic [DATA_BITS-1:0] i_data,
    output logic [DATA_BITS-1:0] o_data
);

    assign o_data = i_data[DATA_BITS-1] ? '0 : i_data;

endmodule

// File: rtl/feature_map_collector.sv
// Feature-map collector: assembles an H*W row-major frame from a pixel stream and holds it for
// the pool stage under a valid/ready handshake.
// Optional feature: define RELU_EN to clamp negative pixels to zero on the slot-write path.
module feature_map_collector
    import feature_map_collector_pkg::*;
#(
    parameter int unsigned DATA_BITS = FMC_DATA_BITS,
    parameter int unsigned W         = FMC_W,
    parameter int unsigned H         = FMC_H
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic [DATA_BITS-1:0]     i_in_data,
    input  logic                     i_in_valid,
    input  logic                     i_in_last,
    output logic                     o_in_ready,
    output logic [H*W*DATA_BITS-1:0] o_frame_data,
    output logic                     o_frame_valid,
    input  logic                     i_frame_ready,
    output logic                     o_err_frame
);

    localparam int unsigned NPix    = H * W;
    localparam int unsigned IdxBits = $clog2(NPix);

    state_e                   r_state;
    state_e                   w_state_next;
    logic [IdxBits-1:0]       r_idx;
    logic [IdxBits-1:0]       w_idx_next;
    logic [NPix*DATA_BITS-1:0] r_frame;
    logic                     r_frame_valid;
    logic                     r_err_frame;
    logic                     w_err_next;
    logic                     w_accept;
    logic                     w_last_slot;
    logic [NPix-1:0]          w_slot_we;
    logic [DATA_BITS-1:0]     w_pixel;

`ifdef RELU_EN
    pixel_relu #(
        .DATA_BITS (DATA_BITS)
    ) u_pixel_relu (
        .i_data (i_in_data),
        .o_data (w_pixel)
    );
`else
    assign w_pixel = i_in_data;
`endif

    assign o_in_ready    = (r_state == FILL);
    assign w_accept      = i_in_valid && o_in_ready;
    assign w_last_slot   = (r_idx == IdxBits'(NPix - 1));
    assign o_frame_data  = r_frame;
    assign o_frame_valid = r_frame_valid;
    assign o_err_frame   = r_err_frame;

    // Next-state, slot counter and framing-error decode.
    always_comb begin
        w_state_next = r_state;
        w_idx_next   = r_idx;
        w_err_next   = 1'b0;
        unique case (r_state)
            FILL: begin
                if (w_accept) begin
                    if (w_last_slot) begin
                        // Frame is delivered even when in_last is missing; flag it anyway.
                        w_state_next = FULL;
                        w_idx_next   = '0;
                        w_err_next   = !i_in_last;
                    end else if (i_in_last) begin
                        // Short frame: drop it, stale slots get overwritten by the next frame.
                        w_idx_next = '0;
                        w_err_next = 1'b1;
                    end else begin
                        w_idx_next = r_idx + IdxBits'(1);
                    end
                end
            end
            FULL: begin
                if (i_frame_ready) begin
                    w_state_next = FILL;
                end
            end
            default: w_state_next = FILL;
        endcase
    end

    // Per-slot write enables decoded from the slot counter.
    always_comb begin
        w_slot_we = '0;
        for (int unsigned s = 0; s < NPix; s++) begin
            w_slot_we[s] = w_accept && (r_idx == IdxBits'(s));
        end
    end

    // Control registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= FILL;
            r_idx         <= '0;
            r_frame_valid <= 1'b0;
            r_err_frame   <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_idx         <= w_idx_next;
            r_frame_valid <= (w_state_next == FULL);
            r_err_frame   <= w_err_next;
        end
    end

    // Frame storage: each slot loads only on its own write enable, so a held frame stays stable.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_frame <= '0;
        end else begin
            for (int unsigned s = 0; s < NPix; s++) begin
                if (w_slot_we[s]) begin
                    r_frame[s*DATA_BITS +: DATA_BITS] <= w_pixel;
                end
            end
        end
    end

endmodule
